// File: rtl/fifo_uart_tx_pkg.sv
// Shared UART definitions: FSM state encoding, oversampling ratio and counter sizing.
// Imported by the transmitter (and later by the receiver).
package uart_defs;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_START = 2'b01,
    ST_DATA  = 2'b10,
    ST_STOP  = 2'b11
  } state_t;

  localparam int OVERSAMPLE = 16;

  // The tick counter must hold both OVERSAMPLE-1 and SB_TICK-1; 5 bits covers
  // every stop length up to 31 ticks.
  function automatic int tick_cnt_width(input int sb_tick);
    return (sb_tick > 31) ? $clog2(sb_tick) : 5;
  endfunction

endpackage

// File: rtl/fifo_uart_tx_baud_tick_gen.sv
// Mod-DVSR counter producing a one-cycle tick every DVSR clocks.
// The clr input lets a frame restart the baud phase from its first cycle.
module baud_tick_gen #(
  parameter int DVSR       = 163,
  parameter int DVSR_WIDTH = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic tick
);

  logic [DVSR_WIDTH-1:0] cnt_reg;

  assign tick = (cnt_reg == DVSR_WIDTH'(DVSR - 1));

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      cnt_reg <= '0;
    end else if (tick) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

endmodule

// File: rtl/fifo_uart_tx.sv
// UART transmitter draining a show-ahead FIFO: pops a word while idle and sends
// it LSB first as start / data / stop, 16 baud ticks per bit.
module fifo_uart_tx
  import uart_defs::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int SB_TICK    = 16,
  parameter int DVSR       = 163,
  parameter int DVSR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  empty,
  input  logic [DATA_WIDTH-1:0] r_data,
  output logic                  rd,
  output logic                  tx,
  output logic                  tx_busy
);

  localparam int TICK_W = tick_cnt_width(SB_TICK);
  localparam int BIT_W  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [TICK_W-1:0] OS_LAST  = TICK_W'(OVERSAMPLE - 1);
  localparam logic [TICK_W-1:0] SB_LAST  = TICK_W'(SB_TICK - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST = BIT_W'(DATA_WIDTH - 1);

  state_t                state_reg;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic [DATA_WIDTH-1:0] shift_next;
  logic [BIT_W-1:0]      bit_cnt_reg;
  logic [TICK_W-1:0]     tick_cnt_reg;
  logic                  tx_reg;
  logic                  busy_reg;
  logic                  tick;

  // The pop is combinational so the FIFO advances on the same edge the word is latched.
  assign rd         = (state_reg == ST_IDLE) && !empty && !reset;
  assign shift_next = shift_reg >> 1;
  assign tx         = tx_reg;
  assign tx_busy    = busy_reg;

  baud_tick_gen #(
    .DVSR       (DVSR),
    .DVSR_WIDTH (DVSR_WIDTH)
  ) u_baud (
    .clk   (clk),
    .reset (reset),
    .clr   (rd),
    .tick  (tick)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= ST_IDLE;
      shift_reg    <= '0;
      bit_cnt_reg  <= '0;
      tick_cnt_reg <= '0;
      tx_reg       <= 1'b1;
      busy_reg     <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          tx_reg <= 1'b1;
          if (rd) begin
            shift_reg    <= r_data;
            tick_cnt_reg <= '0;
            bit_cnt_reg  <= '0;
            tx_reg       <= 1'b0;
            busy_reg     <= 1'b1;
            state_reg    <= ST_START;
          end
        end

        ST_START: begin
          if (tick) begin
            if (tick_cnt_reg == OS_LAST) begin
              tick_cnt_reg <= '0;
              bit_cnt_reg  <= '0;
              tx_reg       <= shift_reg[0];
              state_reg    <= ST_DATA;
            end else begin
              tick_cnt_reg <= tick_cnt_reg + 1'b1;
            end
          end
        end

        ST_DATA: begin
          if (tick) begin
            if (tick_cnt_reg == OS_LAST) begin
              tick_cnt_reg <= '0;
              shift_reg    <= shift_next;
              if (bit_cnt_reg == BIT_LAST) begin
                tx_reg    <= 1'b1;
                state_reg <= ST_STOP;
              end else begin
                // tx is registered, so present the next bit from the post-shift value.
                tx_reg      <= shift_next[0];
                bit_cnt_reg <= bit_cnt_reg + 1'b1;
              end
            end else begin
              tick_cnt_reg <= tick_cnt_reg + 1'b1;
            end
          end
        end

        ST_STOP: begin
          tx_reg <= 1'b1;
          if (tick) begin
            if (tick_cnt_reg == SB_LAST) begin
              tick_cnt_reg <= '0;
              busy_reg     <= 1'b0;
              state_reg    <= ST_IDLE;
            end else begin
              tick_cnt_reg <= tick_cnt_reg + 1'b1;
            end
          end
        end

        default: begin
          state_reg <= ST_IDLE;
          tx_reg    <= 1'b1;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed/random bench for fifo_uart_tx: a queue-based FIFO feeds two instances
// (1 and 1.5 stop bits); every sampled line cycle is compared with an ideal frame.
module tb_fifo_uart_tx;

  localparam int DVSR = 2;
  localparam int BITP = 16 * DVSR;
  localparam int LOGN = 8000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset0, empty0, rd0, tx0, busy0;
  logic [7:0] r_data0;
  logic       reset1, empty1, rd1, tx1, busy1;
  logic [7:0] r_data1;

  fifo_uart_tx #(.DATA_WIDTH(8), .SB_TICK(16), .DVSR(DVSR), .DVSR_WIDTH(8)) dut0 (
    .clk(clk), .reset(reset0), .empty(empty0), .r_data(r_data0),
    .rd(rd0), .tx(tx0), .tx_busy(busy0)
  );

  fifo_uart_tx #(.DATA_WIDTH(8), .SB_TICK(24), .DVSR(DVSR), .DVSR_WIDTH(8)) dut1 (
    .clk(clk), .reset(reset1), .empty(empty1), .r_data(r_data1),
    .rd(rd1), .tx(tx1), .tx_busy(busy1)
  );

  int cyc = 0;
  int total = 0;
  int bad = 0;

  logic       tx_log   [2][LOGN];
  logic       busy_log [2][LOGN];
  logic       rd_log   [2][LOGN];
  logic [7:0] q0[$], q1[$];
  int         rd_c0[$], rd_c1[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive();
    empty0  = (q0.size() == 0);
    r_data0 = empty0 ? 8'h00 : q0[0];
    empty1  = (q1.size() == 0);
    r_data1 = empty1 ? 8'h00 : q1[0];
  endtask

  // One clock: sample outputs mid-cycle, model the FIFO pop at the edge, update inputs after it.
  task automatic cycle();
    @(negedge clk);
    if (cyc < LOGN) begin
      tx_log[0][cyc] = tx0;  busy_log[0][cyc] = busy0; rd_log[0][cyc] = rd0;
      tx_log[1][cyc] = tx1;  busy_log[1][cyc] = busy1; rd_log[1][cyc] = rd1;
    end
    if (rd0 === 1'b1) begin
      rd_c0.push_back(cyc);
      if (q0.size() > 0) void'(q0.pop_front());
    end
    if (rd1 === 1'b1) begin
      rd_c1.push_back(cyc);
      if (q1.size() > 0) void'(q1.pop_front());
    end
    @(posedge clk);
    #1;
    cyc++;
    drive();
  endtask

  function automatic int get_rd(input int sel, input int n);
    if (sel == 0) return (n < rd_c0.size()) ? rd_c0[n] : 0;
    return (n < rd_c1.size()) ? rd_c1[n] : 0;
  endfunction

  // Ideal line level k cycles after the pop: start bit, data LSB first, then stop.
  function automatic logic exp_tx(input logic [7:0] w, input int k);
    if (k < BITP) return 1'b0;
    if (k < 9 * BITP) return w[(k - BITP) / BITP];
    return 1'b1;
  endfunction

  task automatic check_frame(input int sel, input logic [7:0] w, input int rc,
                             input int sb, input string name);
    int flen;
    int busy_sum;
    int idx;
    flen = 9 * BITP + sb * DVSR;
    busy_sum = 0;
    for (int k = 0; k < flen; k++) begin
      idx = rc + 1 + k;
      chk($sformatf("%s tx k=%0d", name, k), tx_log[sel][idx], exp_tx(w, k));
      if (busy_log[sel][idx] === 1'b1) busy_sum++;
    end
    chk({name, " busy_len"}, busy_sum, flen);
    chk({name, " busy_end"}, busy_log[sel][rc + 1 + flen], 0);
    chk({name, " tx_end"}, tx_log[sel][rc + 1 + flen], 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    int n1;
    int c1;
    int c2;
    logic [7:0] w;

    // Reset held with a word waiting: no pop until reset is released.
    reset0 = 1'b1;
    reset1 = 1'b1;
    q0.push_back(8'h3C);
    drive();
    repeat (3) begin
      cycle();
      chk("s1 reset tx", tx_log[0][cyc-1], 1);
      chk("s1 reset rd", rd_log[0][cyc-1], 0);
      chk("s1 reset busy", busy_log[0][cyc-1], 0);
    end
    reset0 = 1'b0;
    reset1 = 1'b0;
    cycle();
    chk("s1 first rd", rd_log[0][cyc-1], 1);
    chk("s1 rd count", rd_c0.size(), 1);
    repeat (330) cycle();
    check_frame(0, 8'h3C, get_rd(0, 0), 16, "s1");

    // Single word.
    n0 = rd_c0.size();
    q0.push_back(8'hA5);
    drive();
    repeat (330) cycle();
    chk("s2 rd count", rd_c0.size() - n0, 1);
    check_frame(0, 8'hA5, get_rd(0, n0), 16, "s2");

    // Back-to-back words: one idle cycle between frames.
    n0 = rd_c0.size();
    q0.push_back(8'h00);
    q0.push_back(8'hFF);
    drive();
    repeat (660) cycle();
    chk("s3 rd count", rd_c0.size() - n0, 2);
    c1 = get_rd(0, n0);
    c2 = get_rd(0, n0 + 1);
    chk("s3 rd gap", c2 - c1, 9 * BITP + 16 * DVSR + 1);
    check_frame(0, 8'h00, c1, 16, "s3a");
    check_frame(0, 8'hFF, c2, 16, "s3b");

    // Empty FIFO for a long stretch.
    n0 = rd_c0.size();
    repeat (2000) begin
      cycle();
      chk("s4 idle rd", rd_log[0][cyc-1], 0);
      chk("s4 idle tx", tx_log[0][cyc-1], 1);
      chk("s4 idle busy", busy_log[0][cyc-1], 0);
    end
    chk("s4 rd count", rd_c0.size() - n0, 0);

    // Reset during data bit 3; the aborted word is dropped and the next one sent whole.
    n0 = rd_c0.size();
    q0.push_back(8'hF0);
    drive();
    cycle();
    repeat (140) cycle();
    reset0 = 1'b1;
    q0.push_back(8'h5A);
    drive();
    cycle();
    chk("s5 pre-reset tx", tx_log[0][cyc-1], exp_tx(8'hF0, 140));
    chk("s5 rd in reset", rd_log[0][cyc-1], 0);
    reset0 = 1'b0;
    cycle();
    chk("s5 post-reset tx", tx_log[0][cyc-1], 1);
    chk("s5 post-reset busy", busy_log[0][cyc-1], 0);
    chk("s5 post-reset rd", rd_log[0][cyc-1], 1);
    repeat (330) cycle();
    chk("s5 rd count", rd_c0.size() - n0, 2);
    check_frame(0, 8'h5A, get_rd(0, n0 + 1), 16, "s5");

    // 1.5 stop bits on the second instance, plus a couple of random words.
    n1 = rd_c1.size();
    q1.push_back(8'h55);
    drive();
    repeat (345) cycle();
    chk("s6 rd count", rd_c1.size() - n1, 1);
    check_frame(1, 8'h55, get_rd(1, n1), 24, "s6");

    for (int r = 0; r < 2; r++) begin
      n0 = rd_c0.size();
      w = 8'($urandom_range(0, 255));
      q0.push_back(w);
      drive();
      repeat (330) cycle();
      chk($sformatf("rnd%0d rd count", r), rd_c0.size() - n0, 1);
      check_frame(0, w, get_rd(0, n0), 16, $sformatf("rnd%0d", r));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
